// File: rtl/key_device_if.sv
// Processor bus port of the key device: address, store/load strobes, read data, decode hit and interrupt.
interface key_device_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wrData;
    logic             wrEn;
    logic             rdEn;
    logic [DBITS-1:0] dataOut;
    logic             hit;
    logic             irq;

    modport master (
        output addr, wrData, wrEn, rdEn,
        input  dataOut, hit, irq
    );

    modport slave (
        input  addr, wrData, wrEn, rdEn,
        output dataOut, hit, irq
    );
endinterface

// File: rtl/key_device.sv
// Memory-mapped debounced key device with KDATA/KCTRL registers.
// Optional KEY_DEVICE_IRQ_EN adds the KCTRL IE bit and the irq output.
module key_device #(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
    parameter logic [15:0]      DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic         clk,
    input  logic         reset_n,
    key_device_if.slave  bus,
    input  logic [3:0]   KEY
);

    logic [3:0]  keyMeta;
    logic [3:0]  keySync;
    logic [3:0]  debKeys;
    logic [3:0]  debNext;
    logic [15:0] cnt     [4];
    logic [15:0] cntNext [4];

    logic             ready;
    logic             overrun;
    logic             ie;
    logic             kdataChange;
    logic             selKdata;
    logic             selKctrl;
    logic             readKdata;
    logic             writeKctrl;
    logic [DBITS-1:0] kdata;
    logic [DBITS-1:0] kctrl;
    logic             unusedWr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keyMeta <= '1;
            keySync <= '1;
        end else begin
            keyMeta <= KEY;
            keySync <= keyMeta;
        end
    end

    // Counter runs only while the synchronized bit disagrees with the accepted state.
    always_comb begin
        debNext = debKeys;
        for (int unsigned i = 0; i < 4; i++) begin
            cntNext[i] = '0;
            if (keySync[i] != debKeys[i]) begin
                if (cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    debNext[i] = keySync[i];
                end else begin
                    cntNext[i] = cnt[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debKeys <= '1;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            debKeys <= debNext;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= cntNext[i];
            end
        end
    end

    assign kdataChange = (debNext != debKeys);
    assign selKdata    = (bus.addr == ADDR_KDATA);
    assign selKctrl    = (bus.addr == ADDR_KCTRL);
    assign readKdata   = bus.rdEn & selKdata;
    assign writeKctrl  = bus.wrEn & selKctrl;
    assign unusedWr    = ^bus.wrData;

    // A read landing on the same edge as a change consumes the old data, so no overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (kdataChange) begin
                ready <= 1'b1;
            end else if (readKdata) begin
                ready <= 1'b0;
            end

            if (kdataChange && ready && !readKdata) begin
                overrun <= 1'b1;
            end else if (writeKctrl && !bus.wrData[2]) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef KEY_DEVICE_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie <= 1'b0;
        end else if (writeKctrl) begin
            ie <= bus.wrData[8];
        end
    end
    assign bus.irq = ready & ie;
`else
    assign ie      = 1'b0;
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        kdata      = '0;
        kdata[3:0] = ~debKeys;
        kctrl      = '0;
        kctrl[0]   = ready;
        kctrl[2]   = overrun;
        kctrl[8]   = ie;
    end

    assign bus.hit = selKdata | selKctrl;

    always_comb begin
        bus.dataOut = '0;
        if (selKdata) begin
            bus.dataOut = kdata;
        end else if (selKctrl) begin
            bus.dataOut = kctrl;
        end
    end

endmodule

// File: tb/tb_key_device.sv
// Directed self-checking bench for key_device with DEBOUNCE_CYCLES=4.
module tb_key_device;

    localparam logic [31:0] KDATA_A = 32'hF0000010;
    localparam logic [31:0] KCTRL_A = 32'hF0000110;
    localparam logic [31:0] OTHER_A = 32'hF0000020;
`ifdef KEY_DEVICE_IRQ_EN
    localparam logic [31:0] IE_BIT  = 32'h100;
`else
    localparam logic [31:0] IE_BIT  = 32'h0;
`endif

    logic       clk;
    logic       reset_n;
    logic [3:0] KEY;
    int         checks;
    int         failures;
    logic [31:0] rd;

    key_device_if #(.DBITS(32)) busIf ();

    key_device #(
        .DBITS(32),
        .ADDR_KDATA(KDATA_A),
        .ADDR_KCTRL(KCTRL_A),
        .DEBOUNCE_CYCLES(16'd4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(busIf),
        .KEY(KEY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkReg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        busIf.addr = a;
        #1;
        checkVal(tag, busIf.dataOut, exp);
    endtask

    task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
        busIf.addr   = a;
        busIf.wrData = d;
        busIf.wrEn   = 1'b1;
        tick();
        busIf.wrEn   = 1'b0;
        busIf.addr   = '0;
    endtask

    task automatic readKdata(input string tag, input logic [31:0] exp);
        busIf.addr = KDATA_A;
        busIf.rdEn = 1'b1;
        #1;
        checkVal(tag, busIf.dataOut, exp);
        tick();
        busIf.rdEn = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset_n      = 1'b0;
        KEY          = 4'hF;
        busIf.addr   = '0;
        busIf.wrData = '0;
        busIf.wrEn   = 1'b0;
        busIf.rdEn   = 1'b0;

        ticks(2);
        checkReg("rst_kdata", KDATA_A, 32'h0);
        checkVal("rst_hit_kdata", {31'b0, busIf.hit}, 32'h1);
        checkReg("rst_kctrl", KCTRL_A, 32'h0);
        checkVal("rst_irq", {31'b0, busIf.irq}, 32'h0);
        checkReg("rst_other", OTHER_A, 32'h0);
        checkVal("rst_hit_other", {31'b0, busIf.hit}, 32'h0);
        reset_n = 1'b1;
        ticks(3);

        // KEY[1] pressed: accepted after 2 sync + 4 stable cycles
        KEY = 4'hD;
        ticks(5);
        checkReg("deb_early", KDATA_A, 32'h0);
        tick();
        checkReg("deb_accept", KDATA_A, 32'h2);
        tick();
        checkReg("deb_ready", KCTRL_A, 32'h1);
        ticks(3);
        readKdata("read_valid", 32'h2);
        checkReg("read_clears", KCTRL_A, 32'h0);
        KEY = 4'hF;
        ticks(6);
        checkReg("release_kdata", KDATA_A, 32'h0);
        tick();
        checkReg("second_change", KCTRL_A, 32'h1);

        // Second change without read: overrun
        KEY = 4'hB;
        ticks(6);
        checkReg("ovr_kdata", KDATA_A, 32'h4);
        tick();
        checkReg("ovr_set", KCTRL_A, 32'h5);
        writeReg(KCTRL_A, 32'h4);
        checkReg("ovr_keep", KCTRL_A, 32'h5);
        writeReg(KCTRL_A, 32'h1);
        checkReg("ovr_clear", KCTRL_A, 32'h1);
        writeReg(KDATA_A, 32'hFFFF_FFFF);
        checkReg("kdata_wr_ignored", KDATA_A, 32'h4);

        busIf.addr   = OTHER_A;
        busIf.wrData = 32'h0;
        busIf.rdEn   = 1'b1;
        busIf.wrEn   = 1'b1;
        #1;
        checkVal("other_data", busIf.dataOut, 32'h0);
        checkVal("other_hit", {31'b0, busIf.hit}, 32'h0);
        tick();
        busIf.rdEn = 1'b0;
        busIf.wrEn = 1'b0;
        checkReg("other_no_effect", KCTRL_A, 32'h1);

        // 3-cycle glitch on KEY[0] must be rejected
        readKdata("glitch_pre_read", 32'h4);
        KEY = 4'hA;
        ticks(3);
        KEY = 4'hB;
        ticks(8);
        checkReg("glitch_kdata", KDATA_A, 32'h4);
        checkReg("glitch_ready", KCTRL_A, 32'h0);

        // Change on the same edge as a KDATA read: change wins, no overrun
        KEY = 4'h3;
        ticks(6);
        checkReg("k3_kdata", KDATA_A, 32'hC);
        tick();
        checkReg("k3_ready", KCTRL_A, 32'h1);
        KEY = 4'hB;
        ticks(5);
        readKdata("race_read_old", 32'hC);
        checkReg("race_kdata", KDATA_A, 32'h4);
        checkReg("race_kctrl", KCTRL_A, 32'h1);

        // Overrun set on the same edge as a clearing KCTRL write: overrun stays
        KEY = 4'hF;
        ticks(5);
        writeReg(KCTRL_A, 32'h0);
        checkReg("race2_kdata", KDATA_A, 32'h0);
        checkReg("race2_kctrl", KCTRL_A, 32'h5);

        // Interrupt enable
        readKdata("irq_pre_read", 32'h0);
        checkReg("irq_pre_kctrl", KCTRL_A, 32'h4);
        writeReg(KCTRL_A, 32'h100);
        checkReg("ie_written", KCTRL_A, IE_BIT);
        checkVal("irq_idle", {31'b0, busIf.irq}, 32'h0);
        KEY = 4'hE;
        ticks(6);
        checkReg("irq_kdata", KDATA_A, 32'h1);
        tick();
        checkReg("irq_kctrl", KCTRL_A, IE_BIT | 32'h1);
        checkVal("irq_asserted", {31'b0, busIf.irq}, (IE_BIT != 0) ? 32'h1 : 32'h0);
        readKdata("irq_read", 32'h1);
        checkVal("irq_cleared", {31'b0, busIf.irq}, 32'h0);
        checkReg("irq_kctrl_after", KCTRL_A, IE_BIT);

        // Reset pulse mid-debounce
        KEY = 4'hC;
        ticks(3);
        reset_n = 1'b0;
        #1;
        checkReg("midrst_kdata", KDATA_A, 32'h0);
        checkReg("midrst_kctrl", KCTRL_A, 32'h0);
        checkVal("midrst_hit", {31'b0, busIf.hit}, 32'h1);
        checkVal("midrst_irq", {31'b0, busIf.irq}, 32'h0);
        ticks(2);
        reset_n = 1'b1;
        ticks(5);
        checkReg("redeb_early", KDATA_A, 32'h0);
        tick();
        checkReg("redeb_kdata", KDATA_A, 32'h3);
        tick();
        checkReg("redeb_ready", KCTRL_A, 32'h1);
        checkVal("redeb_irq", {31'b0, busIf.irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
